// File: rtl/post_rgb2ycbcr_pkg.sv
// Shared constants and helpers for the RGB888 to YCbCr444 (BT.601 full range) converter.
// The coefficients are the 8-bit fixed-point weights; sums are 18-bit two's complement.
package post_rgb2ycbcr_pkg;

  localparam int unsigned CoefYR  = 77;
  localparam int unsigned CoefYG  = 150;
  localparam int unsigned CoefYB  = 29;
  localparam int unsigned CoefCbR = 43;
  localparam int unsigned CoefCbG = 85;
  localparam int unsigned CoefCbB = 128;
  localparam int unsigned CoefCrR = 128;
  localparam int unsigned CoefCrG = 107;
  localparam int unsigned CoefCrB = 21;

  localparam int unsigned OffY = 128;
  localparam int unsigned OffC = 32768;

  localparam int unsigned Latency = 3;
  localparam int unsigned CntW    = 16;

  localparam int unsigned PixW  = 8;
  localparam int unsigned ProdW = 16;
  localparam int unsigned SumW  = 18;

  typedef struct packed {
    logic [ProdW-1:0] yr;
    logic [ProdW-1:0] yg;
    logic [ProdW-1:0] yb;
    logic [ProdW-1:0] cbr;
    logic [ProdW-1:0] cbg;
    logic [ProdW-1:0] cbb;
    logic [ProdW-1:0] crr;
    logic [ProdW-1:0] crg;
    logic [ProdW-1:0] crb;
  } prod_t;

  // Sum bits are two's complement; sat_pix reinterprets them as signed.
  typedef struct packed {
    logic [SumW-1:0] y;
    logic [SumW-1:0] cb;
    logic [SumW-1:0] cr;
  } sum_t;

  function automatic logic [PixW-1:0] sat_pix(input logic signed [SumW-1:0] s);
    logic signed [SumW-9:0] sh;
    logic [PixW-1:0]        res;
    sh = $signed(s[SumW-1:8]);
    if (sh < 0) begin
      res = '0;
    end else if (sh > 255) begin
      res = '1;
    end else begin
      res = sh[PixW-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/post_sync_dly.sv
// Fixed-depth delay line for the {v_sync, h_sync, valid} bundle, keeping
// control aligned with the datapath pipeline.
module post_sync_dly
  import post_rgb2ycbcr_pkg::*;
#(
  parameter int unsigned Depth = Latency
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [2:0] d_i,
  output logic [2:0] q_o
);

  logic [Depth-1:0][2:0] sr_d, sr_q;

  always_comb begin
    sr_d[0] = d_i;
    for (int unsigned i = 1; i < Depth; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign q_o = sr_q[Depth-1];

endmodule

// File: rtl/post_rgb2ycbcr.sv
// RGB888 to YCbCr444 converter: 3-stage pipeline (products, sums, shift/saturate).
// Define POST_RGB2YCBCR_LINE_CHK_EN to build the sticky line-length checker.
module post_rgb2ycbcr
  import post_rgb2ycbcr_pkg::*;
#(
  parameter int unsigned IMG_W  = 1280,
  parameter int unsigned DATA_W = 8
) (
  input  logic              I_Clk,
  input  logic              I_Rsy,
  input  logic              I_V_Sync,
  input  logic              I_H_Sync,
  input  logic              I_RGB_Vaild,
  input  logic [DATA_W-1:0] I_RGB_Data_r,
  input  logic [DATA_W-1:0] I_RGB_Data_g,
  input  logic [DATA_W-1:0] I_RGB_Data_b,
  output logic              O_V_Sync,
  output logic              O_H_Sync,
  output logic              O_YCbCr_Vaild,
  output logic [DATA_W-1:0] O_Y_Data,
  output logic [DATA_W-1:0] O_Cb_Data,
  output logic [DATA_W-1:0] O_Cr_Data,
  output logic              O_Line_Err
);

  prod_t             prod_d, prod_q;
  sum_t              sum_d, sum_q;
  logic [DATA_W-1:0] y_d, y_q, cb_d, cb_q, cr_d, cr_q;
  logic [2:0]        sync_dly;

  always_comb begin
    prod_d.yr  = ProdW'(I_RGB_Data_r) * ProdW'(CoefYR);
    prod_d.yg  = ProdW'(I_RGB_Data_g) * ProdW'(CoefYG);
    prod_d.yb  = ProdW'(I_RGB_Data_b) * ProdW'(CoefYB);
    prod_d.cbr = ProdW'(I_RGB_Data_r) * ProdW'(CoefCbR);
    prod_d.cbg = ProdW'(I_RGB_Data_g) * ProdW'(CoefCbG);
    prod_d.cbb = ProdW'(I_RGB_Data_b) * ProdW'(CoefCbB);
    prod_d.crr = ProdW'(I_RGB_Data_r) * ProdW'(CoefCrR);
    prod_d.crg = ProdW'(I_RGB_Data_g) * ProdW'(CoefCrG);
    prod_d.crb = ProdW'(I_RGB_Data_b) * ProdW'(CoefCrB);
  end

  // Modulo-2^18 arithmetic yields the same bits as the signed sum.
  always_comb begin
    sum_d.y  = SumW'(prod_q.yr) + SumW'(prod_q.yg) + SumW'(prod_q.yb) + SumW'(OffY);
    sum_d.cb = SumW'(OffC) - SumW'(prod_q.cbr) - SumW'(prod_q.cbg) + SumW'(prod_q.cbb);
    sum_d.cr = SumW'(OffC) + SumW'(prod_q.crr) - SumW'(prod_q.crg) - SumW'(prod_q.crb);
  end

  always_comb begin
    y_d  = DATA_W'(sat_pix(sum_q.y));
    cb_d = DATA_W'(sat_pix(sum_q.cb));
    cr_d = DATA_W'(sat_pix(sum_q.cr));
  end

  always_ff @(posedge I_Clk or posedge I_Rsy) begin
    if (I_Rsy) begin
      prod_q <= '0;
      sum_q  <= '0;
      y_q    <= '0;
      cb_q   <= '0;
      cr_q   <= '0;
    end else begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
      y_q    <= y_d;
      cb_q   <= cb_d;
      cr_q   <= cr_d;
    end
  end

  post_sync_dly #(
    .Depth (Latency)
  ) u_sync_dly (
    .clk_i (I_Clk),
    .rst_i (I_Rsy),
    .d_i   ({I_V_Sync, I_H_Sync, I_RGB_Vaild}),
    .q_o   (sync_dly)
  );

  assign O_V_Sync      = sync_dly[2];
  assign O_H_Sync      = sync_dly[1];
  assign O_YCbCr_Vaild = sync_dly[0];

  // Blank data outside valid so downstream never sees bubbles' stale values.
  assign O_Y_Data  = O_YCbCr_Vaild ? y_q  : '0;
  assign O_Cb_Data = O_YCbCr_Vaild ? cb_q : '0;
  assign O_Cr_Data = O_YCbCr_Vaild ? cr_q : '0;

`ifdef POST_RGB2YCBCR_LINE_CHK_EN
  logic            vld_q, vs_q, err_d, err_q;
  logic [CntW-1:0] cnt_d, cnt_q;
  logic            vld_fall, vs_rise;

  always_comb begin
    vld_fall = vld_q & ~I_RGB_Vaild;
    vs_rise  = I_V_Sync & ~vs_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (I_RGB_Vaild && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (vld_fall) begin
      cnt_d = '0;
      if (cnt_q != CntW'(IMG_W)) begin
        err_d = 1'b1;
      end
    end
    // Frame start clears after the compare so it wins a same-cycle mismatch.
    if (vs_rise) begin
      cnt_d = '0;
      err_d = 1'b0;
    end
  end

  always_ff @(posedge I_Clk or posedge I_Rsy) begin
    if (I_Rsy) begin
      vld_q <= 1'b0;
      vs_q  <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= I_RGB_Vaild;
      vs_q  <= I_V_Sync;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign O_Line_Err = err_q;
`else
  logic unused_img_w;
  assign unused_img_w = ^IMG_W;
  assign O_Line_Err   = 1'b0;
`endif

endmodule
